vga_pixel_feeder: RTL and testbench

//  Upstream pixel source for the VGA timing/colour stage. Buffers RRGGBB pixels from a host write port in a

---
 rtl/vga_feeder_pkg.sv | 25 ++
 rtl/vga_sync_fifo.sv | 52 +++++
 rtl/vga_pixel_feeder.sv | 151 +++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_feeder_pkg.sv
// Shared types and constants for the VGA pixel feeder: FSM states, control words and default raster timing.
package vga_feeder_pkg;

   typedef enum logic [1:0] {
      ST_RESYNC = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2
   } feeder_state_t;

   localparam logic [7:0] SYNC_WORD  = 8'h03;
   localparam logic [7:0] BLANK_WORD = 8'h00;

   localparam int DEPTH_DEF    = 16;
   localparam int PREFILL_DEF  = 8;
   localparam int H_ACTIVE_DEF = 640;
   localparam int LINE_DEF     = 800;
   localparam int V_ACTIVE_DEF = 480;
   localparam int SCREEN_DEF   = 525;

   // Pixel words always carry ctl=2'b00 so the downstream counters free-run.
   function automatic logic [7:0] pixel_word(input logic [5:0] rgb);
      return {rgb, 2'b00};
   endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, synchronous flush and occupancy output; no fall-through.
module vga_sync_fifo
   import vga_feeder_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk_pix,
   input  logic                       rst_pix,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk_pix or negedge rst_pix) begin
      if (!rst_pix) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Pixel source for the VGA timing stage: FIFO-buffered host pixels, mirrored raster, registered output word.
// Optional VGA_FEEDER_AUTOSYNC_EN: a frame with any underrun forces a flush and resync at the frame wrap.
module vga_pixel_feeder
   import vga_feeder_pkg::*;
#(
   parameter int         DEPTH           = DEPTH_DEF,
   parameter int         PREFILL         = PREFILL_DEF,
   parameter int         H_ACTIVE        = H_ACTIVE_DEF,
   parameter int         LINE            = LINE_DEF,
   parameter int         V_ACTIVE        = V_ACTIVE_DEF,
   parameter int         SCREEN          = SCREEN_DEF,
   parameter logic [5:0] UNDERRUN_COLOUR = 6'b000000
) (
   input  logic                       clk_pix,
   input  logic                       rst_pix,
   input  logic [5:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       frame_start,
   output logic [7:0]                 wb_data,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [1:0]                 state,
   output logic                       underrun
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int XW = $clog2(LINE);
   localparam int YW = $clog2(SCREEN);

   feeder_state_t   r_state;
   logic [7:0]      r_wb;
   logic            r_under;
   logic [XW-1:0]   r_px;
   logic [YW-1:0]   r_py;

   logic            w_full;
   logic            w_empty;
   logic [5:0]      w_head;
   logic [LW-1:0]   w_level;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_resync_wrap;
   logic            w_last_px;
   logic            w_last_py;
   logic            w_wrap;
   logic [XW-1:0]   w_tx;
   logic [YW-1:0]   w_ty;
   logic            w_active;
   logic            w_fill_done;
   logic            w_emit;
   logic            w_under;
   logic [7:0]      w_word;

   assign in_ready   = !w_full && !frame_start;
   assign w_push     = in_valid && in_ready;
   assign wb_data    = r_wb;
   assign fifo_level = w_level;
   assign state      = r_state;
   assign underrun   = r_under;

   vga_sync_fifo #(
      .WIDTH (6),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (in_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // The position computed here is the one the next registered word belongs to.
   assign w_last_px   = (r_px == XW'(LINE - 1));
   assign w_last_py   = (r_py == YW'(SCREEN - 1));
   assign w_wrap      = w_last_px && w_last_py;
   assign w_tx        = (r_state == ST_STREAM && !w_last_px) ? r_px + 1'b1 : '0;
   assign w_ty        = (r_state != ST_STREAM) ? '0 :
                        !w_last_px             ? r_py :
                        w_last_py              ? '0 : r_py + 1'b1;
   assign w_active    = (w_tx < XW'(H_ACTIVE)) && (w_ty < YW'(V_ACTIVE));
   assign w_fill_done = (r_state == ST_FILL) && (w_level >= LW'(PREFILL));
   assign w_flush     = frame_start || w_resync_wrap;
   assign w_emit      = !w_flush && ((r_state == ST_STREAM) || w_fill_done);
   assign w_pop       = w_emit && w_active && !w_empty;
   assign w_under     = w_emit && w_active && w_empty;
   assign w_word      = !w_active ? BLANK_WORD :
                        w_empty   ? pixel_word(UNDERRUN_COLOUR) : pixel_word(w_head);

`ifdef VGA_FEEDER_AUTOSYNC_EN
   logic r_flag;

   assign w_resync_wrap = (r_state == ST_STREAM) && w_wrap && r_flag;

   always_ff @(posedge clk_pix or negedge rst_pix) begin
      if (!rst_pix)     r_flag <= 1'b0;
      else if (w_flush) r_flag <= 1'b0;
      else if (w_under) r_flag <= 1'b1;
   end
`else
   assign w_resync_wrap = 1'b0;
`endif

   always_ff @(posedge clk_pix or negedge rst_pix) begin
      if (!rst_pix) begin
         r_state <= ST_RESYNC;
         r_wb    <= BLANK_WORD;
         r_under <= 1'b0;
         r_px    <= '0;
         r_py    <= '0;
      end else begin
         r_under <= w_under;
         if (w_flush) begin
            r_state <= ST_RESYNC;
            r_wb    <= SYNC_WORD;
         end else begin
            case (r_state)
               ST_RESYNC: begin
                  r_state <= ST_FILL;
                  r_wb    <= SYNC_WORD;
               end
               ST_FILL: begin
                  if (w_fill_done) begin
                     r_state <= ST_STREAM;
                     r_px    <= w_tx;
                     r_py    <= w_ty;
                     r_wb    <= w_word;
                  end else begin
                     r_wb    <= SYNC_WORD;
                  end
               end
               ST_STREAM: begin
                  r_px <= w_tx;
                  r_py <= w_ty;
                  r_wb <= w_word;
               end
               default: begin
                  r_state <= ST_RESYNC;
                  r_wb    <= SYNC_WORD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder on a 12x6 raster (8x4 active), DEPTH=16, PREFILL=8.
module tb_vga_pixel_feeder;

   logic       clk_pix = 1'b0;
   logic       rst_pix;
   logic [5:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       frame_start;
   logic [7:0] wb_data;
   logic [4:0] fifo_level;
   logic [1:0] state;
   logic       underrun;

   int n_cmp  = 0;
   int n_fail = 0;

   vga_pixel_feeder #(
      .DEPTH           (16),
      .PREFILL         (8),
      .H_ACTIVE        (8),
      .LINE            (12),
      .V_ACTIVE        (4),
      .SCREEN          (6),
      .UNDERRUN_COLOUR (6'b000000)
   ) dut (
      .clk_pix     (clk_pix),
      .rst_pix     (rst_pix),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .frame_start (frame_start),
      .wb_data     (wb_data),
      .fifo_level  (fifo_level),
      .state       (state),
      .underrun    (underrun)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_pix);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_pix     = 1'b0;
      in_data     = 6'h00;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      tick(2);
      chk("rst_wb", wb_data, 8'h00);
      chk("rst_state", state, 2'd0);
      chk("rst_level", fifo_level, 5'd0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_ready", in_ready, 1'b1);

      // Reset release: one sync word from RESYNC, then FILL holds it
      rst_pix = 1'b1;
      tick(1);
      chk("resync_wb", wb_data, 8'h03);
      chk("resync_to_fill", state, 2'd1);
      chk("fill_ready", in_ready, 1'b1);
      tick(1);
      chk("fill_hold_wb", wb_data, 8'h03);
      chk("fill_hold_state", state, 2'd1);
      chk("fill_level0", fifo_level, 5'd0);

      // Prefill 0x01..0x08, then line 0 streams them
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 6'(i);
         tick(1);
         chk("prefill_level", fifo_level, 32'(i));
         chk("prefill_state", state, 2'd1);
      end
      in_valid = 1'b0;
      tick(1);
      chk("stream_enter", state, 2'd2);
      chk("px0_wb", wb_data, 8'h04);
      chk("px0_level", fifo_level, 5'd7);
      for (int i = 2; i <= 8; i++) begin
         tick(1);
         chk("row0_wb", wb_data, 32'(i * 4));
         chk("row0_level", fifo_level, 32'(8 - i));
      end
      tick(1);
      chk("blank8_wb", wb_data, 8'h00);
      chk("blank8_level", fifo_level, 5'd0);
      tick(1);
      chk("blank9_wb", wb_data, 8'h00);
      chk("blank9_underrun", underrun, 1'b0);
      in_valid = 1'b1; in_data = 6'h11;
      tick(1);
      chk("blank10_level", fifo_level, 5'd1);
      in_data = 6'h22;
      tick(1);
      chk("blank11_level", fifo_level, 5'd2);
      chk("blank11_wb", wb_data, 8'h00);
      in_valid = 1'b0;

      // Line 1: push+pop at (1,1), underrun at (3,1) and at (4,1) with a same-clock push
      tick(1);
      chk("p01_wb", wb_data, 8'h44);
      chk("p01_level", fifo_level, 5'd1);
      in_valid = 1'b1; in_data = 6'h2A;
      tick(1);
      chk("p11_wb", wb_data, 8'h88);
      chk("p11_pushpop_level", fifo_level, 5'd1);
      in_valid = 1'b0;
      tick(1);
      chk("p21_wb", wb_data, 8'hA8);
      chk("p21_level", fifo_level, 5'd0);
      tick(1);
      chk("p31_wb", wb_data, 8'h00);
      chk("p31_underrun", underrun, 1'b1);
      chk("p31_level", fifo_level, 5'd0);
      chk("p31_state", state, 2'd2);
      in_valid = 1'b1; in_data = 6'h15;
      tick(1);
      chk("p41_underrun", underrun, 1'b1);
      chk("p41_level", fifo_level, 5'd1);
      in_valid = 1'b0;
      tick(1);
      chk("p51_wb", wb_data, 8'h54);
      chk("p51_underrun", underrun, 1'b0);
      chk("p51_level", fifo_level, 5'd0);

      // Advance to (5,2), then frame_start with a competing write
      tick(12);
      chk("p52_state", state, 2'd2);
      frame_start = 1'b1;
      in_valid    = 1'b1;
      in_data     = 6'h3F;
      #1;
      chk("fs_ready", in_ready, 1'b0);
      tick(1);
      frame_start = 1'b0;
      in_valid    = 1'b0;
      chk("fs_level", fifo_level, 5'd0);
      chk("fs_state", state, 2'd0);
      chk("fs_wb", wb_data, 8'h03);
      tick(1);
      chk("fs_fill_state", state, 2'd1);
      chk("fs_fill_wb", wb_data, 8'h03);
      chk("fs_fill_level", fifo_level, 5'd0);

      // New frame: prefill 0x20..0x27, rows 1..3 will underrun
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 6'(32 + i);
         tick(1);
      end
      in_valid = 1'b0;
      chk("f2_prefill_level", fifo_level, 5'd8);
      tick(1);
      chk("f2_stream", state, 2'd2);
      chk("f2_px0_wb", wb_data, 8'h80);
      tick(7);
      chk("f2_px7_wb", wb_data, 8'h9C);
      chk("f2_px7_level", fifo_level, 5'd0);
      tick(40);
      chk("f2_row3_end_wb", wb_data, 8'h00);

      // Vertical blanking: fill to full with no pops
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         in_data  = 6'(16 + k);
         tick(1);
         chk("vfill_level", fifo_level, 32'(k + 1));
      end
      chk("full_ready", in_ready, 1'b0);
      in_data = 6'h3F;
      tick(1);
      chk("full_ignore_level", fifo_level, 5'd16);
      in_valid = 1'b0;
      tick(7);
      chk("full_hold_ready", in_ready, 1'b0);
      chk("full_hold_level", fifo_level, 5'd16);
      tick(1);
`ifdef VGA_FEEDER_AUTOSYNC_EN
      chk("wrap_autosync_state", state, 2'd0);
      chk("wrap_autosync_level", fifo_level, 5'd0);
      chk("wrap_autosync_wb", wb_data, 8'h03);
      chk("wrap_autosync_ready", in_ready, 1'b1);
      tick(1);
      chk("wrap_autosync_fill", state, 2'd1);
      chk("wrap_autosync_fill_wb", wb_data, 8'h03);
`else
      chk("wrap_state", state, 2'd2);
      chk("wrap_first_pop_wb", wb_data, 8'h40);
      chk("wrap_level", fifo_level, 5'd15);
      chk("wrap_ready", in_ready, 1'b1);
      chk("wrap_underrun", underrun, 1'b0);
      tick(1);
      chk("wrap_second_wb", wb_data, 8'h44);
      chk("wrap_second_level", fifo_level, 5'd14);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
